// File: rtl/ddr_rd_capture_ctrl.sv
// ddr_rd_capture_ctrl: times IFDDRRSE capture windows after READs, packs beats, buffers bursts.
// Define RD_ERR_EN to flag READ strobes issued while cmd_ready is low (sticky rd_err).
module ddr_rd_capture_ctrl #(
    parameter int WIDTH   = 16,
    parameter int BURST   = 4,
    parameter int CL      = 2,
    parameter int PENDING = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cmd_read,
    output logic                     cmd_ready,
    output logic                     cap_ce,
    output logic                     cap_rst,
    input  logic [WIDTH-1:0]         cap_q0,
    input  logic [WIDTH-1:0]         cap_q1,
    output logic [BURST*WIDTH-1:0]   rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     rd_err
);
    localparam int B2 = BURST / 2;
    localparam int L  = CL + B2;
    localparam int AW = $clog2(PENDING);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(B2 + 1);

    logic                   run;
    logic [L-1:0]           wheel;
    logic [CW-1:0]          count, wptr, rptr;
    logic [GW-1:0]          gap;
    logic [BURST*WIDTH-1:0] acc, acc_nxt;
    logic [BURST*WIDTH-1:0] mem [PENDING];
    logic                   accept, pop, last;

    assign cmd_ready = run && (count < CW'(PENDING)) && (gap == '0);
    assign accept    = cmd_read && cmd_ready;
    assign rd_valid  = wptr != rptr;
    assign pop       = rd_valid && rd_ready;
    assign last      = wheel[L-1];
    assign cap_ce    = |wheel[L-2:CL-1];
    assign cap_rst   = !run;
    assign rd_data   = rd_valid ? mem[rptr[AW-1:0]] : '0;

    // Windows never overlap, so at most one wheel bit in the capture range is set.
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < B2; i++)
            if (wheel[CL+i]) acc_nxt[2*i*WIDTH +: 2*WIDTH] = {cap_q1, cap_q0};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run   <= 1'b0;
            wheel <= '0;
            count <= '0;
            gap   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            acc   <= '0;
        end else begin
            run   <= 1'b1;
            wheel <= {wheel[L-2:0], accept};
            gap   <= accept ? GW'(B2 - 1) : (gap != '0 ? gap - 1'b1 : gap);
            acc   <= acc_nxt;
            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;
            if (last)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock)
        if (last) mem[wptr[AW-1:0]] <= acc_nxt;

`ifdef RD_ERR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rd_err <= 1'b0;
        else if (cmd_read && !cmd_ready)
            rd_err <= 1'b1;
    end
`else
    assign rd_err = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_rd_capture_ctrl.sv
// tb_ddr_rd_capture_ctrl: directed bench for ddr_rd_capture_ctrl (CL=2 main instance, CL=3 second).
module tb_ddr_rd_capture_ctrl;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_read, cmd_ready, cap_ce, cap_rst, rd_valid, rd_ready, rd_err;
    logic        cmd_read3, cmd_ready3, cap_ce3, cap_rst3, rd_valid3, rd_ready3, rd_err3;
    logic [15:0] cap_q0, cap_q1;
    logic [63:0] rd_data, rd_data3;
    int          checks = 0, failures = 0, cyc = 0;
    int          cnt_m = 0, gap_m = 0, k3;
    bit          auto_q = 0;
    int          pend[$];
    logic [63:0] fq[$];

    always #5 clock = ~clock;

    ddr_rd_capture_ctrl #(.WIDTH(16), .BURST(4), .CL(2), .PENDING(4)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_read(cmd_read), .cmd_ready(cmd_ready),
        .cap_ce(cap_ce), .cap_rst(cap_rst), .cap_q0(cap_q0), .cap_q1(cap_q1),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_err(rd_err));

    ddr_rd_capture_ctrl #(.WIDTH(16), .BURST(4), .CL(3), .PENDING(4)) dut3 (
        .clock(clock), .reset_n(reset_n), .cmd_read(cmd_read3), .cmd_ready(cmd_ready3),
        .cap_ce(cap_ce3), .cap_rst(cap_rst3), .cap_q0(cap_q0), .cap_q1(cap_q1),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_ready(rd_ready3), .rd_err(rd_err3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beat data on the DQ bus is a function of the cycle number once auto_q is set.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (auto_q) begin
            cap_q0 = {4'hA, 12'(cyc)};
            cap_q1 = {4'hB, 12'(cyc)};
        end
    endtask

    function automatic logic [63:0] eb(input int k, input int d);
        return {4'hB, 12'(k+d+1), 4'hA, 12'(k+d+1), 4'hB, 12'(k+d), 4'hA, 12'(k+d)};
    endfunction

    // One cycle against the scoreboard: check outputs, clock, update expected state.
    task automatic step(input logic rd, input logic rr);
        logic a, p;
        cmd_read = rd;
        rd_ready = rr;
        chk("cmd_ready", cmd_ready, 64'(cnt_m < 4 && gap_m == 0));
        chk("rd_valid", rd_valid, 64'(fq.size() != 0));
        if (fq.size() != 0) chk("rd_data", rd_data, fq[0]);
        a = rd && cnt_m < 4 && gap_m == 0;
        p = fq.size() != 0 && rr;
        tick();
        if (p) void'(fq.pop_front());
        cnt_m += int'(a) - int'(p);
        gap_m = a ? 1 : (gap_m > 0 ? gap_m - 1 : 0);
        if (a) pend.push_back(cyc);
        if (pend.size() != 0 && pend[0] + 4 == cyc) fq.push_back(eb(pend.pop_front(), 2));
    endtask

    initial begin
        cmd_read = 0; rd_ready = 0; cmd_read3 = 0; rd_ready3 = 0; cap_q0 = '0; cap_q1 = '0;
        #2;
        chk("rst_cap_ce", cap_ce, 0);
        chk("rst_cap_rst", cap_rst, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_err", rd_err, 0);
        #10 reset_n = 1'b1;
        tick();
        chk("rel_cap_rst", cap_rst, 0);
        chk("rel_cmd_ready", cmd_ready, 1);

        // single READ with hand-placed beats
        cmd_read = 1; tick(); cmd_read = 0;
        chk("t1_ce_k", cap_ce, 0);
        chk("t1_gap", cmd_ready, 0);
        tick();
        chk("t1_ce_k1", cap_ce, 1);
        tick();
        chk("t1_ce_k2", cap_ce, 1);
        cap_q0 = 16'h1111; cap_q1 = 16'h2222;
        tick();
        chk("t1_ce_k3", cap_ce, 0);
        chk("t1_valid_k3", rd_valid, 0);
        cap_q0 = 16'h3333; cap_q1 = 16'h4444;
        tick();
        chk("t1_valid_k4", rd_valid, 1);
        chk("t1_data", rd_data, 64'h4444_3333_2222_1111);
        rd_ready = 1; tick(); rd_ready = 0;
        chk("t1_pop_valid", rd_valid, 0);
        chk("t1_pop_data", rd_data, 0);

        // four READs with client stalled, then drain in order
        auto_q = 1;
        for (int j = 0; j < 4; j++) begin
            step(1, 0);
            step(0, 0);
        end
        chk("t2_full", cmd_ready, 0);
        repeat (6) step(0, 0);
        chk("t2_held", rd_valid, 1);
        repeat (6) step(0, 1);

        // streaming READs with a toggling client
        for (int i = 0; i < 24; i++) step(i % 2 == 0 && i < 16, (i % 3) != 0);
        repeat (12) step(0, 1);

        // back-to-back strobe: second one ignored
        step(1, 0);
        step(1, 0);
        step(0, 0);
`ifdef RD_ERR_EN
        chk("t4_rd_err", rd_err, 1);
`else
        chk("t4_rd_err", rd_err, 0);
`endif
        repeat (8) step(0, 1);

        // reset mid-window
        step(1, 0);
        step(0, 0);
        chk("t5_ce_pre", cap_ce, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_cap_ce", cap_ce, 0);
        chk("t5_cap_rst", cap_rst, 1);
        chk("t5_cmd_ready", cmd_ready, 0);
        chk("t5_rd_valid", rd_valid, 0);
        chk("t5_rd_data", rd_data, 0);
        chk("t5_rd_err", rd_err, 0);
        #10 reset_n = 1'b1;
        pend.delete(); fq.delete(); cnt_m = 0; gap_m = 0;
        tick();
        repeat (6) step(0, 0);

        // CL=3 instance
        cmd_read3 = 1; tick(); cmd_read3 = 0;
        k3 = cyc;
        for (int i = 0; i < 6; i++) begin
            chk("t6_ce", cap_ce3, 64'(i == 2 || i == 3));
            chk("t6_valid", rd_valid3, 64'(i == 5));
            if (i == 5) chk("t6_data", rd_data3, eb(k3, 3));
            else tick();
        end
        rd_ready3 = 1; tick(); rd_ready3 = 0;
        chk("t6_pop", rd_valid3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
